// File: rtl/fib_datapath.sv
// rtl/fib_datapath.sv - sixteen-register ALU datapath with registered flags and readout port
module fib_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] RegEnable,
  input  logic [3:0]  MuxControlA,
  input  logic [3:0]  MuxControlB,
  input  logic        MuxControlC,
  input  logic [15:0] AluControl,
  input  logic [3:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic [15:0] alu_out,
  output logic [4:0]  flags,
  output logic [15:0] result_q
);

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_LSH = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;

  logic [15:0] regs [16];
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] imm_ext;
  logic [3:0]  op;
  logic [16:0] sum;
  logic [16:0] diff;
  logic        writes;
  logic [4:0]  flags_next;

  assign op      = AluControl[7:4];
  assign imm_ext = {{8{AluControl[15]}}, AluControl[15:8]};
  assign op_a    = regs[MuxControlA];
  assign op_b    = MuxControlC ? imm_ext : regs[MuxControlB];
  assign rd_data = regs[rd_sel];

  // Zero-extended 17-bit forms: bit 16 is carry for ADD, borrow (A < B) for SUB/CMP.
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_out    = '0;
    writes     = 1'b1;
    flags_next = flags;
    case (op)
      OP_ADD: begin
        alu_out    = sum[15:0];
        flags_next = {sum[16], 1'b0,
                      (op_a[15] == op_b[15]) && (sum[15] != op_a[15]),
                      sum[15:0] == 16'd0, sum[15]};
      end
      OP_SUB, OP_CMP: begin
        alu_out    = diff[15:0];
        writes     = (op == OP_SUB);
        flags_next = {diff[16], diff[16],
                      (op_a[15] != op_b[15]) && (diff[15] != op_a[15]),
                      diff[15:0] == 16'd0, diff[15]};
      end
      OP_AND: alu_out = op_a & op_b;
      OP_OR:  alu_out = op_a | op_b;
      OP_XOR: alu_out = op_a ^ op_b;
      OP_MOV: alu_out = op_b;
      OP_LSH: alu_out = op_b[4] ? (op_a >> op_b[3:0]) : (op_a << op_b[3:0]);
      default: writes = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      flags    <= '0;
      result_q <= '0;
    end else begin
      flags <= flags_next;
      if (writes) begin
        for (int i = 0; i < 16; i++)
          if (RegEnable[i]) regs[i] <= alu_out;
        if (RegEnable != 16'd0) result_q <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_fib_datapath.sv
// tb/tb_fib_datapath.sv - directed and random checks of fib_datapath against an arithmetic reference model
module tb_fib_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] RegEnable = '0;
  logic [3:0]  MuxControlA = '0;
  logic [3:0]  MuxControlB = '0;
  logic        MuxControlC = 1'b0;
  logic [15:0] AluControl = '0;
  logic [3:0]  rd_sel = '0;
  logic [15:0] rd_data;
  logic [15:0] alu_out;
  logic [4:0]  flags;
  logic [15:0] result_q;

  int checks = 0;
  int errors = 0;

  int       ref_r [16];
  int       ref_result;
  bit [4:0] ref_flags;

  fib_datapath dut (
    .clk(clk), .reset(reset), .RegEnable(RegEnable),
    .MuxControlA(MuxControlA), .MuxControlB(MuxControlB), .MuxControlC(MuxControlC),
    .AluControl(AluControl), .rd_sel(rd_sel), .rd_data(rd_data),
    .alu_out(alu_out), .flags(flags), .result_q(result_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference ALU in plain integer arithmetic.
  task automatic model(input int op, input int a, input int b,
                       output int res, output bit wr, output bit fu, output bit [4:0] fl);
    int full, sres;
    bit c, l, f;
    c = 0; l = 0; f = 0; wr = 1; fu = 0; res = 0;
    case (op)
      5: begin
        full = a + b; res = full % 65536; c = (full > 65535);
        sres = to_signed(a) + to_signed(b); f = (sres > 32767) || (sres < -32768); fu = 1;
      end
      9, 11: begin
        full = a - b; res = (full + 65536) % 65536; c = (a < b); l = (a < b);
        sres = to_signed(a) - to_signed(b); f = (sres > 32767) || (sres < -32768);
        fu = 1; wr = (op == 9);
      end
      1:  res = a & b;
      2:  res = a | b;
      3:  res = a ^ b;
      13: res = b;
      4:  res = ((b & 16) != 0) ? (a >> (b % 16)) : ((a << (b % 16)) & 65535);
      default: wr = 0;
    endcase
    fl = {c, l, f, res == 0, res >= 32768};
  endtask

  task automatic step(input logic [15:0] ren, input int ma, input int mb, input bit mc,
                      input int op, input int imm, input int rs);
    int a, b, res;
    bit wr, fu;
    bit [4:0] fl;
    @(negedge clk);
    RegEnable   = ren;
    MuxControlA = 4'(ma);
    MuxControlB = 4'(mb);
    MuxControlC = mc;
    AluControl  = {8'(imm), 4'(op), 4'($urandom)};
    rd_sel      = 4'(rs);
    a = ref_r[ma];
    b = mc ? ((imm >= 128) ? imm + 65280 : imm) : ref_r[mb];
    model(op, a, b, res, wr, fu, fl);
    #1;
    check("alu_out", alu_out, 16'(res));
    check("rd_before_edge", rd_data, 16'(ref_r[rs]));
    @(posedge clk);
    if (wr) begin
      for (int i = 0; i < 16; i++) if (ren[i]) ref_r[i] = res;
      if (ren != 0) ref_result = res;
    end
    if (fu) ref_flags = fl;
    #1;
    check("flags", 16'(flags), 16'(ref_flags));
    check("result_q", result_q, 16'(ref_result));
    check("rd_after_edge", rd_data, 16'(ref_r[rs]));
    RegEnable  = '0;
    AluControl = '0;
  endtask

  task automatic peek(input string tag, input int idx, input logic [15:0] exp);
    rd_sel = 4'(idx);
    #1;
    check(tag, rd_data, exp);
  endtask

  // Reset is applied alongside an active full-width write that must be discarded.
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    RegEnable   = 16'hFFFF;
    MuxControlC = 1'b1;
    AluControl  = {8'h55, 4'b1101, 4'h0};
    @(posedge clk);
    #1;
    reset      = 1'b0;
    RegEnable  = '0;
    AluControl = '0;
    for (int i = 0; i < 16; i++) ref_r[i] = 0;
    ref_result = 0;
    ref_flags  = '0;
    for (int i = 0; i < 16; i++) peek("reset_reg", i, 16'h0000);
    check("reset_flags", 16'(flags), 16'h0000);
    check("reset_result_q", result_q, 16'h0000);
  endtask

  task automatic fib(input int last);
    step(16'h0001, 0, 0, 1, 13, 8'h01, 0);
    step(16'h0002, 0, 0, 0, 5, 0, 1);
    for (int k = 2; k <= last; k++) step(16'(1 << k), k - 2, k - 1, 0, 5, 0, k);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_r[i] = 0;
    ref_result = 0;
    ref_flags  = '0;
    repeat (2) @(posedge clk);
    do_reset();

    step(16'h0001, 0, 0, 1, 13, 8'h01, 0);
    peek("mov_r0", 0, 16'h0001);
    check("mov_result_q", result_q, 16'h0001);
    check("mov_flags", 16'(flags), 16'h0000);

    fib(15);
    peek("fib_r15", 15, 16'h063D);
    peek("fib_r14", 14, 16'h03DB);

    step(16'h0004, 0, 0, 1, 13, 8'hFF, 2);
    step(16'h0008, 2, 0, 1, 4, 8'h11, 3);
    step(16'h0010, 0, 0, 1, 13, 8'h01, 4);
    step(16'h0400, 3, 4, 0, 5, 0, 10);
    check("add_ovf_result", result_q, 16'h8000);
    check("add_ovf_flags", 16'(flags), 16'b00101);
    step(16'h0020, 2, 4, 0, 5, 0, 5);
    check("add_carry_result", result_q, 16'h0000);
    check("add_carry_flags", 16'(flags), 16'b10010);

    step(16'h0040, 0, 0, 1, 13, 8'h03, 6);
    step(16'h0080, 0, 0, 1, 13, 8'h05, 7);
    step(16'hFFFF, 6, 7, 0, 11, 0, 6);
    check("cmp_flags", 16'(flags), 16'b11001);
    peek("cmp_no_write_r7", 7, 16'h0005);
    step(16'h0100, 0, 0, 1, 13, 8'h00, 8);
    step(16'h0200, 8, 0, 1, 9, 8'hFF, 9);
    peek("sub_imm_r9", 9, 16'h0001);

    step(16'hA000, 6, 7, 0, 5, 0, 13);
    peek("multi_r13", 13, 16'h0008);
    peek("multi_r15", 15, 16'h0008);
    peek("multi_r14_kept", 14, 16'h03DB);

    step(16'h0008, 0, 0, 1, 13, 8'h42, 3);
    peek("rdw_r3", 3, 16'h0042);

    for (int n = 0; n < 300; n++)
      step(16'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
           $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 15));

    fib(5);
    do_reset();
    step(16'h0001, 0, 0, 1, 13, 8'h07, 0);
    peek("post_reset_r0", 0, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
